// File: rtl/ucsbece154b_mem_pkg.sv
// Shared memory-system types and default latency/size constants.
package ucsbece154b_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_BURST,
        ST_WR_WAIT
    } mem_state_t;

    localparam int unsigned MEM_DEPTH_WORDS = 16384;
    localparam int unsigned MEM_BLOCK_WORDS = 4;
    localparam int unsigned MEM_T0_DELAY    = 40;
    localparam int unsigned MEM_T_DELAY     = 4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ucsbece154b_mem_array.sv
// DEPTH_WORDS x 32 storage: one synchronous write port, one combinational read port.
module ucsbece154b_mem_array
    import ucsbece154b_mem_pkg::*;
#(
    parameter  int unsigned DEPTH_WORDS = MEM_DEPTH_WORDS,
    localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // Write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ucsbece154b_mem_responder.sv
// Main-memory responder: block reads and single-word writes with programmable latency.
module ucsbece154b_mem_responder
    import ucsbece154b_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = MEM_DEPTH_WORDS,
    parameter int unsigned BLOCK_WORDS = MEM_BLOCK_WORDS,
    parameter int unsigned T0_DELAY    = MEM_T0_DELAY,
    parameter int unsigned T_DELAY     = MEM_T_DELAY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ReadRequest_i,
    input  logic [31:0] ReadAddress_i,
    input  logic        WriteRequest_i,
    input  logic [31:0] WriteAddress_i,
    input  logic [31:0] WriteData_i,
    output logic        Accept_o,
    output logic        Busy_o,
    output logic [31:0] DataIn_o,
    output logic        DataReady_o,
    output logic        BurstLast_o
);

    localparam int unsigned IW = $clog2(DEPTH_WORDS);
    localparam int unsigned WW = $clog2(BLOCK_WORDS) + 1;
    localparam int unsigned CW = $clog2(max_u(T0_DELAY, T_DELAY)) + 1;

    // The accept cycle plus the final wait cycle are not counted, hence T0-2.
    localparam logic [CW-1:0] T0_LOAD   = (T0_DELAY > 1) ? CW'(T0_DELAY - 2) : '0;
    localparam logic [CW-1:0] T_LOAD    = CW'(T_DELAY - 1);
    localparam logic [WW-1:0] LAST_WORD = WW'(BLOCK_WORDS - 1);
    localparam logic [IW-1:0] BASE_MASK = ~IW'(BLOCK_WORDS - 1);

    mem_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [IW-1:0] base_q, base_d;

    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_req_idx;
    logic [31:0]   rdata;
    logic          idle;
    logic          wr_accept;
    logic          beat;
    logic          unused_addr_bits;

    assign idle       = (state_q == ST_IDLE);
    assign rd_req_idx = ReadAddress_i[IW+1:2];
    assign wr_idx     = WriteAddress_i[IW+1:2];
    assign rd_idx     = base_q + IW'(wcnt_q);
    assign wr_accept  = idle && WriteRequest_i;
    assign beat       = (state_q == ST_RD_BURST) && (cnt_q == '0);

    assign unused_addr_bits = ^{ReadAddress_i[31:IW+2], ReadAddress_i[1:0],
                                WriteAddress_i[31:IW+2], WriteAddress_i[1:0]};

    assign Accept_o    = idle && (ReadRequest_i || WriteRequest_i);
    assign Busy_o      = !idle;
    assign DataReady_o = beat;
    assign BurstLast_o = beat && (wcnt_q == LAST_WORD);
    assign DataIn_o    = beat ? rdata : '0;

    ucsbece154b_mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .we   (wr_accept),
        .waddr(wr_idx),
        .wdata(WriteData_i),
        .raddr(rd_idx),
        .rdata(rdata)
    );

    // State, latency counter, word counter and burst base registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            base_q  <= base_d;
        end
    end

    // Next-state logic: write wins over read in IDLE; counters pace the words.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        base_d  = base_q;
        unique case (state_q)
            ST_IDLE: begin
                if (WriteRequest_i) begin
                    cnt_d   = T0_LOAD;
                    state_d = (T0_DELAY > 1) ? ST_WR_WAIT : ST_IDLE;
                end else if (ReadRequest_i) begin
                    base_d  = rd_req_idx & BASE_MASK;
                    wcnt_d  = '0;
                    cnt_d   = T0_LOAD;
                    state_d = (T0_DELAY > 1) ? ST_RD_WAIT : ST_RD_BURST;
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RD_BURST;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RD_BURST: begin
                if (cnt_q == '0) begin
                    if (wcnt_q == LAST_WORD) begin
                        state_d = ST_IDLE;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                        cnt_d  = T_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WR_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
